// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux -- N-channel, W-bit registered data selector with manual and
// automatic round-robin scanning.
//
// In manual mode the channel comes from sel_in (out-of-range values are
// ignored). In auto mode a dwell counter holds each channel for DWELL cycles
// before stepping to the next one, wrapping from CHANNELS-1 back to 0, so a
// display can cycle through its inputs without anyone touching the switches.
//
// Parameters:
//   WIDTH    bit width of each channel
//   CHANNELS number of channels (2..16, not necessarily a power of two)
//   SEL_W    width of the selection ports (2**SEL_W >= CHANNELS)
//   DWELL    cycles each channel is held in auto mode (>= 1)
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   din      packed channel data, channel k at [k*WIDTH +: WIDTH]
//   mode     0 = manual, 1 = auto scan
//   sel_in   manual channel selection
//   hold     auto mode only: freezes the dwell counter and current channel
//   dout     registered data of the selected channel
//   sel_out  registered index of the selected channel
//   step     one-cycle pulse in the cycle sel_out takes a new value
// ---------------------------------------------------------------------------
module scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 50000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      hold,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      step
);

    // A counter that must reach DWELL-1 needs clog2(DWELL) bits; DWELL=1
    // still gets a one-bit counter that simply stays at zero.
    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

    // Reject parameter sets the selector cannot represent.
    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
        $error("scan_mux: CHANNELS must be in 2..16");
    end
    if ((1 << SEL_W) < CHANNELS) begin : g_bad_sel_w
        $error("scan_mux: SEL_W too narrow for CHANNELS");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("scan_mux: DWELL must be at least 1");
    end

    logic [SEL_W-1:0] sel_q,  sel_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             step_q, step_d;

    // Selection and dwell counter next state.
    always_comb begin
        sel_d = sel_q;
        cnt_d = cnt_q;
        if (!mode) begin
            // Manual: counter parked at 0 so a later switch to auto starts
            // with a full dwell on the current channel.
            cnt_d = '0;
            if (int'(sel_in) < CHANNELS) begin
                sel_d = sel_in;
            end
        end else if (!hold) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                // Explicit wrap: CHANNELS need not be a power of two.
                sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Data uses the selection being registered this edge, so dout and
    // sel_out always describe the same channel.
    always_comb begin
        dout_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(sel_d) == k) begin
                dout_d = din[k*WIDTH +: WIDTH];
            end
        end
    end

    // Pulse only on an actual change; reselecting the same channel is silent.
    always_comb begin
        step_d = (sel_d != sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            step_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            step_q <= step_d;
        end
    end

    assign dout    = dout_q;
    assign sel_out = sel_q;
    assign step    = step_q;

endmodule

// File: tb/tb_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_scan_mux -- directed bench for scan_mux.
// Two instances share the stimulus: u0 (WIDTH=4, CHANNELS=3, SEL_W=2,
// DWELL=3) and u1 (same, DWELL=1). A behavioural model tracks, per instance,
// which channel is shown and how many cycles it has been shown for; every
// clock both instances are compared against it. Directed literal checks on
// u0 pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_scan_mux;

    localparam int W  = 4;
    localparam int CH = 3;
    localparam int SW = 2;

    logic            clk;
    logic            rst;
    logic [CH*W-1:0] din;
    logic            mode;
    logic [SW-1:0]   sel_in;
    logic            hold;

    logic [W-1:0]    dout0, dout1;
    logic [SW-1:0]   sel0,  sel1;
    logic            step0, step1;

    int checks = 0;
    int errors = 0;

    scan_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL(3)) u0 (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .sel_in(sel_in),
        .hold(hold), .dout(dout0), .sel_out(sel0), .step(step0)
    );

    scan_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL(1)) u1 (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .sel_in(sel_in),
        .hold(hold), .dout(dout1), .sel_out(sel1), .step(step1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: channel shown, and cycles it has been shown while scanning.
    // Advancing happens once the channel has been shown for 'dwell' cycles.
    function automatic void model_step(input int dwell, inout int s,
                                       inout int shown, output int st,
                                       output int d);
        int prev;
        prev = s;
        if (rst) begin
            s = 0; shown = 0; st = 0; d = 0;
            return;
        end
        if (!mode) begin
            shown = 0;
            if (int'(sel_in) < CH) s = int'(sel_in);
        end else if (!hold) begin
            shown = shown + 1;
            if (shown == dwell) begin
                shown = 0;
                s = (s + 1) % CH;
            end
        end
        st = (s != prev) ? 1 : 0;
        d  = int'((din >> (s * W)) & 12'hF);
    endfunction

    int m0_s = 0, m0_c = 0, m0_st = 0, m0_d = 0;
    int m1_s = 0, m1_c = 0, m1_st = 0, m1_d = 0;

    // Per-cycle compare, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        model_step(3, m0_s, m0_c, m0_st, m0_d);
        model_step(1, m1_s, m1_c, m1_st, m1_d);
        #1;
        chk("model u0 dout",    int'(dout0), m0_d);
        chk("model u0 sel_out", int'(sel0),  m0_s);
        chk("model u0 step",    int'(step0), m0_st);
        chk("model u1 dout",    int'(dout1), m1_d);
        chk("model u1 sel_out", int'(sel1),  m1_s);
        chk("model u1 step",    int'(step1), m1_st);
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int exp_sel [10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    int exp_step[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int exp_dat [3]  = '{'hC, 'h5, 'hA};

    initial begin
        rst = 1'b1; mode = 1'b1; hold = 1'b0; sel_in = '0; din = 12'h321;

        // Reset held two cycles
        edges(2);
        chk("reset dout",    int'(dout0), 0);
        chk("reset sel_out", int'(sel0),  0);
        chk("reset step",    int'(step0), 0);
        rst = 1'b0;
        edges(1);
        chk("post-reset dout",    int'(dout0), 'h1);
        chk("post-reset sel_out", int'(sel0),  0);

        // Manual select
        mode = 1'b0; din = 12'hA5C; sel_in = 2'd2;
        edges(1);
        chk("manual dout",    int'(dout0), 'hA);
        chk("manual sel_out", int'(sel0),  2);
        chk("manual step",    int'(step0), 1);
        edges(1);
        chk("manual held step", int'(step0), 0);
        chk("manual held sel",  int'(sel0),  2);

        // Out-of-range selection is ignored
        sel_in = 2'd1;
        edges(1);
        chk("sel1 sel_out", int'(sel0),  1);
        chk("sel1 step",    int'(step0), 1);
        chk("sel1 dout",    int'(dout0), 'h5);
        sel_in = 2'd3;
        edges(1);
        chk("oor sel_out", int'(sel0),  1);
        chk("oor step",    int'(step0), 0);
        chk("oor dout",    int'(dout0), 'h5);

        // Auto wrap from channel 0
        sel_in = 2'd0;
        edges(2);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                mode = 1'b1;
                edges(1);
            end
            chk("wrap sel_out", int'(sel0),  exp_sel[i]);
            chk("wrap step",    int'(step0), exp_step[i]);
            chk("wrap dout",    int'(dout0), exp_dat[exp_sel[i]]);
        end

        // Advance to channel 1 with one cycle of its dwell consumed
        edges(4);
        chk("pre-hold sel_out", int'(sel0), 1);
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din = 12'(12'hA0C | (k << 4));
            edges(1);
            chk("hold dout",    int'(dout0), k);
            chk("hold sel_out", int'(sel0),  1);
            chk("hold step",    int'(step0), 0);
        end
        hold = 1'b0;
        edges(1);
        chk("release +1 sel_out", int'(sel0), 1);
        edges(1);
        chk("release +2 sel_out", int'(sel0),  2);
        chk("release +2 step",    int'(step0), 1);

        // Reset mid-scan, then a full dwell on channel 0
        rst = 1'b1;
        edges(1);
        chk("midreset sel_out", int'(sel0),  0);
        chk("midreset dout",    int'(dout0), 0);
        chk("midreset step",    int'(step0), 0);
        rst = 1'b0;
        edges(1);
        chk("dwell1 sel_out", int'(sel0), 0);
        edges(1);
        chk("dwell2 sel_out", int'(sel0), 0);
        edges(1);
        chk("dwell3 sel_out", int'(sel0),  1);
        chk("dwell3 step",    int'(step0), 1);

        // Auto -> manual, same channel then a new one
        mode = 1'b0; sel_in = 2'd1;
        edges(1);
        chk("to manual sel_out", int'(sel0),  1);
        chk("to manual step",    int'(step0), 0);
        sel_in = 2'd2;
        edges(1);
        chk("manual2 sel_out", int'(sel0),  2);
        chk("manual2 step",    int'(step0), 1);
        chk("manual2 dout",    int'(dout0), 'hA);

        edges(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised N-channel, W-bit registered data selector; next generation of the board's 2-to-1 selector.
- Manual mode: a user selection picks the channel.
- Auto mode: a dwell counter steps through all channels round-robin. This lets the board LEDs or 7-segment display cycle through inputs without the user touching the switches.
- Sits between switch/input logic and display drivers.

Parameters:
- WIDTH, 8, bit width of each channel.
- CHANNELS, 4, number of input channels; legal range 2..16, need not be a power of two.
- SEL_W, 2, width of selection ports; must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 50000000, clock cycles each channel is held in auto mode (1 s at 50 MHz); minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = auto scan.
- sel_in  input  SEL_W  manual channel selection.
- hold  input  1  auto mode only: 1 freezes the dwell counter and the current channel.
- dout  output  WIDTH  registered selected channel data.
- sel_out  output  SEL_W  currently selected channel index (registered).
- step  output  1  one-cycle pulse in the cycle sel_out takes a new value.

Behaviour:
- Reset: one clock, synchronous, active-high, as decided. While rst is high at a clock edge:
  - dout <= 0, sel_out <= 0, step <= 0.
  - Dwell counter <= 0. rst overrides all other inputs.
- Internal state:
  - cur_sel register (drives sel_out).
  - Dwell counter, width clog2(DWELL) minimum 1.
  - dout register.
- Data path:
  - dout <= din[cur_sel_next]: dout reflects the selection and data sampled in the same edge.
  - Latency is 1 clock from a din change or selection change to dout.
- Manual mode (mode=0):
  - If sel_in < CHANNELS: cur_sel <= sel_in.
  - If sel_in >= CHANNELS (out of range): cur_sel holds its previous value; no step.
  - Dwell counter is held at 0. hold is ignored.
- Auto mode (mode=1, hold=0):
  - Counter increments every cycle.
  - When counter == DWELL-1: counter <= 0 and cur_sel advances.
  - Advance rule: cur_sel <= (cur_sel == CHANNELS-1) ? 0 : cur_sel+1. Wrap is explicit, not modulo 2**SEL_W.
  - Each channel is therefore held exactly DWELL cycles.
  - DWELL=1 advances every cycle.
- Auto mode with hold=1: counter and cur_sel frozen; dout still tracks din of the frozen channel.
- Mode transitions:
  - Manual -> auto: scan starts from the current cur_sel; counter starts from 0, so the first dwell is a full DWELL cycles.
  - Auto -> manual: sel_in applies on that same edge (subject to the range rule).
  - hold rising mid-dwell preserves the partial count; release resumes from it.
- step:
  - High for exactly one cycle, aligned with the edge where sel_out changes value.
  - Manual reselection of the same channel produces no step.
- Reset mid-scan: next cycle sel_out=0, counter=0; if mode=1, the scan restarts at channel 0 with a full dwell.
- No combinational path from any input to any output.

Test Plan (use WIDTH=4, CHANNELS=3, SEL_W=2, DWELL=3 unless stated):
- Reset: din=0x321, mode=1, rst high 2 cycles -> dout=0, sel_out=0, step=0 during reset; first post-reset edge gives dout=0x1.
- Manual select: mode=0, din=0xA5C, sel_in=2 -> next edge dout=0xA, sel_out=2, step=1 for one cycle; sel_in=2 held -> step stays 0.
- Out of range: mode=0, sel_out=1, sel_in=3 -> sel_out stays 1, dout=din[1], no step.
- Auto wrap: mode=1 from sel_out=0 -> sel_out sequence 0,0,0,1,1,1,2,2,2,0 on successive cycles; step pulses exactly at the transitions into 1, 2 and 0.
- Hold: auto mode with counter at 1 on channel 1, hold=1 for 10 cycles -> sel_out stays 1 and dout follows din[1] changes with 1-cycle latency; after release, channel 2 is reached after 2 more cycles.
- Mid-scan reset and mode switch: reset asserted at sel_out=2 -> sel_out=0 with a full 3-cycle dwell after release; switching to mode=0 with sel_in=1 -> sel_out=1 on the next edge.
